vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA video timing generator with built-in test-pattern source. It drives HSync/VSync and RGB for any resolution set by parameters. A clock-enable input lets the pixel rate be a fraction of the system clock. It replaces the fixed 640×480 generator as the display back-end between the frame source (pattern logic or an external pixel pipeline) and the DAC/resistor-ladder pins.

## Interface
- CLOCK_HZ, 25_000_000, system clock frequency; informational, used by benches for period calculation
- H_ACTIVE, 640, visible pixels per line; must be a multiple of 8
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of HSync_o (0 = active-low)
- VSYNC_POL, 0, asserted level of VSync_o
- COLOR_BITS, 4, bits per colour channel
- Clock  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Enable_i  in  1  pixel-rate enable; counters and output stage advance only when 1
- Mode_i  in  2  pattern select: 0 black, 1 colour bars, 2 checkerboard, 3 external
- Red_i, Green_i, Blue_i  in  COLOR_BITS each  external pixel data for (PixelX_o, PixelY_o)
- PixelX_o  out  HW  current horizontal counter, HW = $clog2(H_TOTAL)
- PixelY_o  out  VW  current vertical counter, VW = $clog2(V_TOTAL)
- HSync_o, VSync_o  out  1  sync outputs, polarity per parameters
- Red_o, Green_o, Blue_o  out  COLOR_BITS each  registered colour; 0 during blanking
- Active_o  out  1  registered visible-region flag aligned with colour outputs
- LineStart_o  out  1  one-Clock pulse when output stage presents x=0 of any line
- FrameStart_o  out  1  one-Clock pulse when output stage presents (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Horizontal counter H: 0..H_TOTAL-1, +1 per enabled cycle, wraps to 0. V +1 when H wraps, V wraps to 0 after V_TOTAL-1.
- Regions per line: visible H<H_ACTIVE; hsync asserted for H_ACTIVE+H_FRONT ≤ H < H_ACTIVE+H_FRONT+H_SYNC. Same scheme for V with line indices.
- Visible = (H<H_ACTIVE)&&(V<V_ACTIVE). Outside visible, colours are forced to 0 in all modes.
- Mode is latched into an internal register when the counters are at (0,0). Mid-frame changes of Mode_i take effect at the next frame only.
- Colour bars: 8 bars of H_ACTIVE/8 pixels, in the order white, yellow, cyan, green, magenta, red, blue, black. Full scale = all ones. The bar index comes from a bar-pixel counter, with no divider.
- Checkerboard: white when H[5]^V[5]=1, else black (32×32 squares).
- External: Red_i/Green_i/Blue_i are sampled on the enabled edge at which the counters equal (PixelX_o, PixelY_o).
- Reset: H=V=0. HSync_o=~HSYNC_POL, VSync_o=~VSYNC_POL. Colours 0, Active_o 0, pulses 0. The mode register loads Mode_i.
- A reset mid-frame aborts the frame immediately. The first enabled cycle after reset release presents pixel (0,0) with FrameStart_o.

## Timing
- Output stage (sync, colour, Active_o, pulses) lags the counters by one enabled cycle. Sync and colour of one pixel always appear on the same Clock edge.
- PixelX_o/PixelY_o are the counter registers. External data must be valid while they show the wanted coordinate and Enable_i=1.
- Enable_i=0: counters and output registers hold. LineStart_o/FrameStart_o still deassert after exactly one Clock.
- Enable_i constantly 1: line = H_TOTAL clocks, frame = H_TOTAL·V_TOTAL clocks. Defaults give 800 and 420 000.
- Simultaneous H and V wrap: V goes to 0 and H goes to 0 on the same edge; FrameStart_o and LineStart_o both pulse.

## Test plan
- Defaults, Enable_i=1, Mode_i=1, reset 3 cycles then release -> FrameStart_o period 420 000 clocks, LineStart_o period 800. HSync_o low for 96 clocks beginning 656 clocks after LineStart_o. VSync_o low for lines 490–491.
- Mode 1 -> on line 0, Red_o/Green_o/Blue_o = F/F/F at x=0..79, F/F/0 at x=80..159, … 0/0/0 at x=560..639. Colours are 0 at x=640..799.
- Mode 2 -> pixel (31,0)=white? no: (0,0) black, (32,0) white, (32,32) black. All colours are 0 on lines 480–524.
- Mode 3 with Red_i=PixelX_o[3:0], others 0 -> Red_o at pixel x equals x[3:0] one enabled cycle later. Red_o is 0 when Active_o=0.
- Enable_i toggling 1,0 -> line takes 1600 clocks and every output holds during disabled cycles. Each pulse is high for exactly 1 clock.
- Mode_i 1→2 at line 100, then Reset asserted at line 300 -> bars continue until the next frame would start. Reset returns all outputs to their reset values on the next edge. After release, FrameStart_o pulses on the first enabled cycle and the new frame shows the checkerboard.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/colour timing with built-in test patterns
module vga_timing_gen #(
  parameter int CLOCK_HZ   = 25_000_000,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_BITS = 4,
  localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable_i,
  input  logic [1:0]            Mode_i,
  input  logic [COLOR_BITS-1:0] Red_i,
  input  logic [COLOR_BITS-1:0] Green_i,
  input  logic [COLOR_BITS-1:0] Blue_i,
  output logic [HW-1:0]         PixelX_o,
  output logic [VW-1:0]         PixelY_o,
  output logic                  HSync_o,
  output logic                  VSync_o,
  output logic [COLOR_BITS-1:0] Red_o,
  output logic [COLOR_BITS-1:0] Green_o,
  output logic [COLOR_BITS-1:0] Blue_o,
  output logic                  Active_o,
  output logic                  LineStart_o,
  output logic                  FrameStart_o
);
  localparam int BAR = H_ACTIVE / 8;
  localparam int BW = $clog2(BAR + 1);
  localparam int HB = HW > 5 ? 5 : HW - 1;
  localparam int VB = VW > 5 ? 5 : VW - 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HA = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS0 = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS1 = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VA = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS0 = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS1 = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [BW-1:0] B_LAST = BW'(BAR - 1);
  if (H_ACTIVE % 8 != 0 || CLOCK_HZ <= 0) begin : g_bad_params
    $error("vga_timing_gen: H_ACTIVE must be a multiple of 8 and CLOCK_HZ positive");
  end
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [1:0] mode_q, mode;
  logic [BW-1:0] bar_cnt;
  logic [2:0] bar_idx;
  logic origin, vis, hs_on, vs_on, chk;
  logic [COLOR_BITS-1:0] r, g, b;
  assign PixelX_o = h;
  assign PixelY_o = v;
  // the pixel at (0,0) already uses the freshly latched mode
  always_comb begin
    origin = h == '0 && v == '0;
    mode = origin ? Mode_i : mode_q;
    vis = h < HA && v < VA;
    hs_on = h >= HS0 && h < HS1;
    vs_on = v >= VS0 && v < VS1;
    chk = h[HB] ^ v[VB];
    r = !vis ? '0 : mode == 2'd1 ? {COLOR_BITS{~bar_idx[1]}} : mode == 2'd2 ? {COLOR_BITS{chk}} : mode == 2'd3 ? Red_i : '0;
    g = !vis ? '0 : mode == 2'd1 ? {COLOR_BITS{~bar_idx[2]}} : mode == 2'd2 ? {COLOR_BITS{chk}} : mode == 2'd3 ? Green_i : '0;
    b = !vis ? '0 : mode == 2'd1 ? {COLOR_BITS{~bar_idx[0]}} : mode == 2'd2 ? {COLOR_BITS{chk}} : mode == 2'd3 ? Blue_i : '0;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      h <= '0;
      v <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
      mode_q <= Mode_i;
      HSync_o <= ~HSYNC_POL;
      VSync_o <= ~VSYNC_POL;
      Red_o <= '0;
      Green_o <= '0;
      Blue_o <= '0;
      Active_o <= 1'b0;
      LineStart_o <= 1'b0;
      FrameStart_o <= 1'b0;
    end else begin
      LineStart_o <= Enable_i && h == '0;
      FrameStart_o <= Enable_i && origin;
      if (Enable_i) begin
        h <= h == H_LAST ? '0 : h + 1'b1;
        if (h == H_LAST) v <= v == V_LAST ? '0 : v + 1'b1;
        if (origin) mode_q <= Mode_i;
        // bar counter free-runs and is realigned at every line wrap
        bar_cnt <= (h == H_LAST || bar_cnt == B_LAST) ? '0 : bar_cnt + 1'b1;
        if (h == H_LAST) bar_idx <= '0;
        else if (bar_cnt == B_LAST) bar_idx <= bar_idx + 1'b1;
        HSync_o <= hs_on ? HSYNC_POL : ~HSYNC_POL;
        VSync_o <= vs_on ? VSYNC_POL : ~VSYNC_POL;
        Red_o <= r;
        Green_o <= g;
        Blue_o <= b;
        Active_o <= vis;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a reduced 80x47 raster
module tb_vga_timing_gen;
  localparam int HA = 64, HF = 4, HS = 8, HBK = 4;
  localparam int VA = 40, VF = 2, VS = 2, VBK = 3;
  localparam int HT = HA + HF + HS + HBK;
  localparam int VT = VA + VF + VS + VBK;
  localparam int FR = HT * VT;
  localparam int HW = $clog2(HT), VW = $clog2(VT);

  typedef struct packed {
    logic [HW-1:0] px;
    logic [VW-1:0] py;
    logic hs, vs;
    logic [3:0] r, g, b;
    logic act, ls, fs;
  } out_t;

  logic clk = 1'b0;
  logic Reset = 1'b1, Enable_i = 1'b0;
  logic [1:0] Mode_i = 2'd1;
  logic [3:0] Red_i = '0, Green_i = '0, Blue_i = '0;
  logic [HW-1:0] PixelX_o;
  logic [VW-1:0] PixelY_o;
  logic HSync_o, VSync_o, Active_o, LineStart_o, FrameStart_o;
  logic [3:0] Red_o, Green_o, Blue_o;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HBK),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK)
  ) dut (
    .Clock(clk), .Reset(Reset), .Enable_i(Enable_i), .Mode_i(Mode_i),
    .Red_i(Red_i), .Green_i(Green_i), .Blue_i(Blue_i),
    .PixelX_o(PixelX_o), .PixelY_o(PixelY_o), .HSync_o(HSync_o), .VSync_o(VSync_o),
    .Red_o(Red_o), .Green_o(Green_o), .Blue_o(Blue_o), .Active_o(Active_o),
    .LineStart_o(LineStart_o), .FrameStart_o(FrameStart_o)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int last_fs = -1, fs_per = 0, last_ls = -1, ls_per = 0;
  int mh = 0, mv = 0;
  logic [1:0] mmode = 2'd0;
  out_t eo = '0;
  out_t sb[$];
  logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // reference model: expected registered outputs after the coming edge
  task automatic model(input logic rst, input logic en, input logic [1:0] md,
                       input logic [3:0] ri, input logic [3:0] gi, input logic [3:0] bi);
    int m;
    logic vis, ck;
    logic [2:0] bar;
    if (rst) begin
      mh = 0; mv = 0; mmode = md;
      eo = '0; eo.hs = 1'b1; eo.vs = 1'b1;
    end else if (en) begin
      m = (mh == 0 && mv == 0) ? int'(md) : int'(mmode);
      if (mh == 0 && mv == 0) mmode = md;
      vis = mh < HA && mv < VA;
      bar = vis ? bars[mh / (HA / 8)] : 3'b000;
      ck = (((mh >> 5) ^ (mv >> 5)) & 1) != 0;
      eo.hs = !(mh >= HA + HF && mh < HA + HF + HS);
      eo.vs = !(mv >= VA + VF && mv < VA + VF + VS);
      case (m)
        1: begin eo.r = {4{bar[2]}}; eo.g = {4{bar[1]}}; eo.b = {4{bar[0]}}; end
        2: begin eo.r = {4{ck}}; eo.g = {4{ck}}; eo.b = {4{ck}}; end
        3: begin eo.r = ri; eo.g = gi; eo.b = bi; end
        default: begin eo.r = 0; eo.g = 0; eo.b = 0; end
      endcase
      if (!vis) begin eo.r = 0; eo.g = 0; eo.b = 0; end
      eo.act = vis;
      eo.ls = mh == 0;
      eo.fs = mh == 0 && mv == 0;
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
      eo.px = HW'(mh);
      eo.py = VW'(mv);
    end else begin
      eo.ls = 1'b0;
      eo.fs = 1'b0;
    end
    sb.push_back(eo);
  endtask

  task automatic step(input logic rst, input logic en, input logic [1:0] md);
    out_t got, exp;
    @(negedge clk);
    Reset = rst;
    Enable_i = en;
    Mode_i = md;
    Red_i = 4'(mh);
    Green_i = 4'($urandom);
    Blue_i = 4'($urandom);
    model(rst, en, md, Red_i, Green_i, Blue_i);
    @(posedge clk);
    #1;
    cyc++;
    got = '{PixelX_o, PixelY_o, HSync_o, VSync_o, Red_o, Green_o, Blue_o, Active_o, LineStart_o, FrameStart_o};
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      exp = sb.pop_front();
      check("xy", 64'({got.px, got.py}), 64'({exp.px, exp.py}));
      check("sync", 64'({got.hs, got.vs}), 64'({exp.hs, exp.vs}));
      check("rgb", 64'({got.r, got.g, got.b}), 64'({exp.r, exp.g, exp.b}));
      check("flags", 64'({got.act, got.ls, got.fs}), 64'({exp.act, exp.ls, exp.fs}));
    end
    if (FrameStart_o) begin
      if (last_fs >= 0) fs_per = cyc - last_fs;
      last_fs = cyc;
    end
    if (LineStart_o) begin
      if (last_ls >= 0) ls_per = cyc - last_ls;
      last_ls = cyc;
    end
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b1, 2'd1);
    repeat (2 * FR + 5) step(1'b0, 1'b1, 2'd1);
    check("frame_period", 64'(fs_per), 64'(FR));
    check("line_period", 64'(ls_per), 64'(HT));
    repeat (2 * FR) step(1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 2 * FR; i++) step(1'b0, i % 2 == 0, 2'd3);
    check("line_period_half_rate", 64'(ls_per), 64'(2 * HT));
    repeat (HT * 10) step(1'b0, 1'b1, 2'd1);
    repeat (HT * 20) step(1'b0, 1'b1, 2'd2);
    repeat (2) step(1'b1, 1'b1, 2'd2);
    last_fs = -1;
    step(1'b0, 1'b1, 2'd2);
    check("fs_after_reset", 64'(last_fs), 64'(cyc));
    repeat (FR + 10) step(1'b0, 1'b1, 2'd2);
    repeat (2000) step(1'b0, 1'($urandom), 2'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
